// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single Register_File write port between the ALU
// writeback source and the load-return source. Each source uses a valid/ready
// handshake and at most one source is granted per cycle. The granted request is
// registered and driven onto Rd/RW/wr one cycle after the transfer.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int FAIR       = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic [ADDR_W-1:0] rf_Rd,
    output logic [DATA_W-1:0] rf_RW,
    output logic              rf_wr,
    output logic              collide
);

    typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    src_e              last_grant_q, last_grant_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              rf_wr_q, rf_wr_d;
    logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0] rf_rw_q, rf_rw_d;
    logic              grant_alu, grant_mem;

    // Grant selection. The same-Rd rule beats both policies: the load is older,
    // so it writes first and the ALU value is the one left in the register.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        collide   = alu_valid && mem_valid && (alu_rd == mem_rd);
        if (!rst) begin
            if (alu_valid && !mem_valid) begin
                grant_alu = 1'b1;
            end else if (mem_valid && !alu_valid) begin
                grant_mem = 1'b1;
            end else if (alu_valid && mem_valid) begin
                if (collide) begin
                    grant_mem = 1'b1;
                end else if (FAIR != 0) begin
                    if (last_grant_q == SRC_MEM) grant_alu = 1'b1;
                    else                         grant_mem = 1'b1;
                end else begin
                    if (starve_cnt_q == STARVE_LIM) grant_alu = 1'b1;
                    else                            grant_mem = 1'b1;
                end
            end
        end
        alu_ready = grant_alu;
        mem_ready = grant_mem;
    end

    // Next-state for arbitration history and the registered write port.
    always_comb begin
        last_grant_d = last_grant_q;
        starve_cnt_d = starve_cnt_q;
        rf_wr_d      = grant_alu || grant_mem;
        rf_rd_d      = rf_rd_q;
        rf_rw_d      = rf_rw_q;
        if (grant_alu) begin
            last_grant_d = SRC_ALU;
            rf_rd_d      = alu_rd;
            rf_rw_d      = alu_data;
        end else if (grant_mem) begin
            last_grant_d = SRC_MEM;
            rf_rd_d      = mem_rd;
            rf_rw_d      = mem_data;
        end
        // Starvation counter only matters under fixed priority; it saturates at the
        // limit so a same-Rd override at the limit keeps the ALU first in line.
        if (FAIR != 0) begin
            starve_cnt_d = '0;
        end else if (!alu_valid || grant_alu) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q < STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= SRC_MEM;
            starve_cnt_q <= '0;
            rf_wr_q      <= 1'b0;
            rf_rd_q      <= '0;
            rf_rw_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            starve_cnt_q <= starve_cnt_d;
            rf_wr_q      <= rf_wr_d;
            rf_rd_q      <= rf_rd_d;
            rf_rw_q      <= rf_rw_d;
        end
    end

    // A write pulse still owed when reset arrives is dropped before the RF commits it.
    assign rf_wr = rf_wr_q && !rst;
    assign rf_Rd = rf_rd_q;
    assign rf_RW = rf_rw_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: one round-robin instance and one fixed-priority
// instance (STARVE_MAX=3) run side by side, each with its own sources, checked
// cycle by cycle against a grant/RF model built from the arbitration rules.
module tb_regfile_wb_arbiter;

    localparam int SMAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  av, mv, ar, mr, coll, wr;
    logic [3:0]  ard [2];
    logic [3:0]  mrd [2];
    logic [3:0]  rd_o [2];
    logic [15:0] adat [2];
    logic [15:0] mdat [2];
    logic [15:0] rw_o [2];

    int          total = 0;
    int          bad   = 0;

    // Model state: d=0 is the round-robin DUT, d=1 the fixed-priority DUT.
    int          lg [2];           // 0 = ALU last granted, 1 = MEM
    int          cnt [2];          // consecutive lost ALU cycles
    bit          pend [2];
    logic [3:0]  prd [2];
    logic [15:0] pdat [2];
    logic [15:0] rf_exp [2][16];
    logic [15:0] rf_got [2][16];
    bit          ar_s [2];
    bit          mr_s [2];
    bit          coll_s [2];

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(4), .FAIR(1), .STARVE_MAX(SMAX)) u_fair (
        .clk(clk), .rst(rst),
        .alu_valid(av[0]), .alu_rd(ard[0]), .alu_data(adat[0]), .alu_ready(ar[0]),
        .mem_valid(mv[0]), .mem_rd(mrd[0]), .mem_data(mdat[0]), .mem_ready(mr[0]),
        .rf_Rd(rd_o[0]), .rf_RW(rw_o[0]), .rf_wr(wr[0]), .collide(coll[0])
    );

    regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(4), .FAIR(0), .STARVE_MAX(SMAX)) u_prio (
        .clk(clk), .rst(rst),
        .alu_valid(av[1]), .alu_rd(ard[1]), .alu_data(adat[1]), .alu_ready(ar[1]),
        .mem_valid(mv[1]), .mem_rd(mrd[1]), .mem_data(mdat[1]), .mem_ready(mr[1]),
        .rf_Rd(rd_o[1]), .rf_RW(rw_o[1]), .rf_wr(wr[1]), .collide(coll[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // 0 = no grant, 1 = ALU, 2 = MEM
    function automatic int model_grant(input int d);
        if (rst) return 0;
        if (av[d] && !mv[d]) return 1;
        if (mv[d] && !av[d]) return 2;
        if (!av[d]) return 0;
        if (ard[d] == mrd[d]) return 2;
        if (d == 0) return (lg[d] == 1) ? 1 : 2;
        return (cnt[d] == SMAX) ? 1 : 2;
    endfunction

    // One clock cycle: inputs are already driven; check, advance model, clock.
    task automatic cyc();
        int g;
        bit ta [2];
        bit tm [2];
        bit exp_wr;
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_wr = pend[d] && !rst;
            chk($sformatf("wr%0d", d), wr[d], exp_wr);
            if (exp_wr) begin
                chk($sformatf("rd%0d", d), rd_o[d], prd[d]);
                chk($sformatf("rw%0d", d), rw_o[d], pdat[d]);
                rf_exp[d][prd[d]] = pdat[d];
            end
            if (wr[d] === 1'b1) rf_got[d][rd_o[d]] = rw_o[d];

            g = model_grant(d);
            chk($sformatf("aready%0d", d), ar[d], g == 1);
            chk($sformatf("mready%0d", d), mr[d], g == 2);
            chk($sformatf("collide%0d", d), coll[d], av[d] && mv[d] && (ard[d] == mrd[d]));
            ar_s[d]   = ar[d];
            mr_s[d]   = mr[d];
            coll_s[d] = coll[d];

            pend[d] = (g != 0);
            prd[d]  = (g == 1) ? ard[d] : mrd[d];
            pdat[d] = (g == 1) ? adat[d] : mdat[d];
            if (rst) begin
                lg[d]  = 1;
                cnt[d] = 0;
            end else begin
                if (g != 0) lg[d] = (g == 1) ? 0 : 1;
                if (!av[d] || g == 1) cnt[d] = 0;
                else if (cnt[d] < SMAX) cnt[d]++;
            end
            ta[d] = (g == 1);
            tm[d] = (g == 2);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (ta[d]) av[d] = 1'b0;
            if (tm[d]) mv[d] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        av  = '0;
        mv  = '0;
        for (int d = 0; d < 2; d++) begin
            ard[d] = 4'h3; mrd[d] = 4'h5; adat[d] = '0; mdat[d] = '0;
            lg[d] = 1; cnt[d] = 0; pend[d] = 0; prd[d] = '0; pdat[d] = '0;
            for (int r = 0; r < 16; r++) begin
                rf_exp[d][r] = '0;
                rf_got[d][r] = '0;
            end
        end

        // Reset held 3 cycles with both sources requesting.
        av = 2'b11;
        mv = 2'b11;
        for (int i = 0; i < 3; i++) cyc();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_rd%0d", d), rd_o[d], 4'h0);
            chk($sformatf("rst_rw%0d", d), rw_o[d], 16'h0);
        end
        rst = 1'b0;
        av  = '0;
        mv  = '0;
        cyc();

        // ALU alone: immediate accept, one-cycle write pulse.
        for (int d = 0; d < 2; d++) begin
            av[d] = 1'b1; ard[d] = 4'hF; adat[d] = 16'h1450;
        end
        cyc();
        for (int d = 0; d < 2; d++) chk($sformatf("t2_acc%0d", d), ar_s[d], 1'b1);
        cyc();
        cyc();
        for (int d = 0; d < 2; d++) chk($sformatf("t2_r15_%0d", d), rf_got[d][15], 16'h1450);

        // Fresh reset, then sustained conflict on distinct rds.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int d = 0; d < 2; d++) begin
                if (!av[d]) begin av[d] = 1'b1; ard[d] = 4'h3; adat[d] = 16'($urandom); end
                if (!mv[d]) begin mv[d] = 1'b1; mrd[d] = 4'h9; mdat[d] = 16'($urandom); end
            end
            cyc();
            chk($sformatf("t3_rr%0d", i), ar_s[0], (i % 2) == 0);
            chk($sformatf("t4_starve%0d", i), ar_s[1], (i % 4) == 3);
        end
        av = '0;
        mv = '0;
        cyc();

        // Same rd from both sources: load first, ALU value survives.
        for (int d = 0; d < 2; d++) begin
            av[d] = 1'b1; ard[d] = 4'h9; adat[d] = 16'h0512;
            mv[d] = 1'b1; mrd[d] = 4'h9; mdat[d] = 16'h2150;
        end
        cyc();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t5_coll%0d", d), coll_s[d], 1'b1);
            chk($sformatf("t5_mem%0d", d), mr_s[d], 1'b1);
        end
        cyc();
        for (int d = 0; d < 2; d++) chk($sformatf("t5_alu%0d", d), ar_s[d], 1'b1);
        cyc();
        cyc();
        for (int d = 0; d < 2; d++) chk($sformatf("t5_r9_%0d", d), rf_got[d][9], 16'h0512);

        // Reset in the cycle that owes the write: write to R10 is lost.
        for (int d = 0; d < 2; d++) begin
            av[d] = 1'b1; ard[d] = 4'hA; adat[d] = 16'h2000;
        end
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t6_ra%0d", d), rf_got[d][10], rf_exp[d][10]);
            chk($sformatf("t6_lost%0d", d), rf_got[d][10] == 16'h2000, 1'b0);
        end

        // Random traffic on a narrow rd range so collisions are frequent.
        for (int i = 0; i < 800; i++) begin
            for (int d = 0; d < 2; d++) begin
                if (!av[d] && $urandom_range(0, 9) < 6) begin
                    av[d] = 1'b1; ard[d] = 4'($urandom_range(0, 3)); adat[d] = 16'($urandom);
                end
                if (!mv[d] && $urandom_range(0, 9) < 6) begin
                    mv[d] = 1'b1; mrd[d] = 4'($urandom_range(0, 3)); mdat[d] = 16'($urandom);
                end
            end
            rst = ($urandom_range(0, 39) == 0);
            cyc();
        end
        rst = 1'b0;
        av  = '0;
        mv  = '0;
        cyc();
        cyc();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 16; r++)
                chk($sformatf("rf%0d_r%0d", d, r), rf_got[d][r], rf_exp[d][r]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
